counter_sched: RTL
==================

COUNTER_SCHED -- requirements
Module: counter_sched

Interface
REQ-001 Parameter WIDTH, default 8, counter and length width in bits.
REQ-002 Parameter NREQ, fixed at 2, number of requesters; other values are not supported.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req  input  2  per-requester request level; held high until done or abandon.
REQ-006 len0  input  WIDTH  requester 0 interval length in counts.
REQ-007 len1  input  WIDTH  requester 1 interval length in counts.
REQ-008 gnt  output  2  one-hot grant, registered; zero when no owner.
REQ-009 busy  output  1  high in LOAD, RUN and DONE states.
REQ-010 done  output  1  one-cycle completion pulse.
REQ-011 done_id  output  1  index of requester that completed; valid only with done.
REQ-012 value  output  WIDTH  shared counter value.

Function
REQ-013 FSM states SHALL be IDLE, LOAD, RUN, DONE, with Moore-decoded outputs.
REQ-014 IDLE: any req high -> LOAD next cycle; winner chosen by round-robin pointer (pointer requester wins ties, else the single requester).
REQ-015 On IDLE->LOAD, winner's len SHALL be latched; later len changes have no effect on the current interval.
REQ-016 LOAD: gnt = one-hot winner, value = 0; next state RUN, or DONE if latched len = 0.
REQ-017 RUN: value increments by 1 per cycle; when value equals latched len, next state DONE.
REQ-018 Latency: req seen in IDLE at cycle T -> gnt at T+1, value = len at T+1+len, done at T+2+len.
REQ-019 DONE: done = 1, done_id = owner, gnt = 0, value holds; pointer set to the other requester; next state IDLE.
REQ-020 value SHALL hold its last count in IDLE until the next LOAD.
REQ-021 Counter SHALL never wrap: len = 2^WIDTH-1 ends at all-ones.
REQ-022 Owner dropping req in LOAD or RUN: abandon -> next state IDLE, gnt = 0, value cleared to 0, no done; pointer moves to the other requester.
REQ-023 Non-owner req changes SHALL NOT affect the active interval; a pending non-owner is served on the next IDLE cycle.
REQ-024 Minimum turnaround: DONE -> IDLE -> LOAD, so back-to-back grants are separated by exactly one IDLE cycle.
REQ-025 gnt SHALL never have more than one bit set.

Reset
REQ-026 reset high SHALL immediately force state IDLE, gnt = 0, busy = 0, done = 0, done_id = 0, value = 0, pointer = 0, latched len = 0.
REQ-027 Reset mid-interval SHALL abandon it with no done pulse; after release, a held req SHALL be granted per REQ-014 with pointer = 0.

Structure
REQ-028 State encoding constants and the NREQ value SHALL live in shared package counter_sched_pkg.
REQ-029 Counting SHALL be a sub-module sched_counter (clk, reset, clear, enable, value) with clear taking priority over enable.
REQ-030 The FSM, arbiter pointer and len latch SHALL reside in counter_sched.

Verification
REQ-031 req=01, len0=5 -> gnt=01 one cycle later; value 0,1..5; done=1, done_id=0 for one cycle; gnt=00.
REQ-032 req=11 from reset, len0=3, len1=2 -> requester 0 served first, done_id=0; one IDLE cycle; requester 1 served, done_id=1.
REQ-033 len1=0, req=10 -> LOAD then DONE directly; done pulse two cycles after request; value stays 0.
REQ-034 len0=10, drop req[0] when value=4 -> next cycle gnt=00, value=0, no done; pending req[1] granted after one IDLE cycle.
REQ-035 Assert reset when value=7 of len0=20 -> all outputs 0 immediately; after release with req=01 held, interval restarts from 0.
REQ-036 WIDTH=8, len0=255 -> value reaches 0xFF without wrap; done asserted; gnt checked one-hot or zero every cycle.

Source files
------------

// File: rtl/counter_sched_pkg.sv
// counter_sched_pkg: shared constants and types for the counter scheduler.
//   NREQ    - number of requesters the scheduler supports (fixed at 2)
//   state_t - scheduler FSM state encoding
package counter_sched_pkg;

  localparam int NREQ = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/sched_counter.sv
// sched_counter: shared up-counter for the scheduler.
//   clk, reset - clock, async active-high reset (value -> 0)
//   clear      - synchronous clear to 0, wins over enable
//   enable     - increment by one this cycle
//   value      - current count
module sched_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  output logic [WIDTH-1:0] value
);

  logic [WIDTH-1:0] value_q, value_d;

  always_comb begin
    value_d = value_q;
    if (clear)       value_d = '0;
    else if (enable) value_d = value_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) value_q <= '0;
    else       value_q <= value_d;
  end

  assign value = value_q;

endmodule

// File: rtl/counter_sched.sv
// counter_sched: two-requester round-robin scheduler that grants a shared
// counter for a latched interval length.
//   clk, reset  - clock, async active-high reset
//   req         - per-requester request level
//   len0, len1  - interval length per requester
//   gnt         - one-hot grant of the current owner (LOAD/RUN only)
//   busy        - high in LOAD, RUN, DONE
//   done        - one-cycle completion pulse (DONE state)
//   done_id     - owner that completed, qualified by done
//   value       - shared counter value
module counter_sched
  import counter_sched_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NREQ  = counter_sched_pkg::NREQ
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NREQ-1:0]  req,
  input  logic [WIDTH-1:0] len0,
  input  logic [WIDTH-1:0] len1,
  output logic [NREQ-1:0]  gnt,
  output logic             busy,
  output logic             done,
  output logic             done_id,
  output logic [WIDTH-1:0] value
);

  state_t           state_q, state_d;
  logic             ptr_q, ptr_d;
  logic             owner_q, owner_d;
  logic [WIDTH-1:0] len_q, len_d;
  logic             cnt_clear, cnt_en;
  logic             win;

  sched_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk    (clk),
    .reset  (reset),
    .clear  (cnt_clear),
    .enable (cnt_en),
    .value  (value)
  );

  // Pointer requester wins a tie; otherwise whoever is asking.
  assign win = req[ptr_q] ? ptr_q : ~ptr_q;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    len_d     = len_q;
    cnt_clear = 1'b0;
    cnt_en    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          state_d   = ST_LOAD;
          owner_d   = win;
          len_d     = win ? len1 : len0;
          // Clear now so value already reads 0 during LOAD.
          cnt_clear = 1'b1;
        end
      end
      ST_LOAD, ST_RUN: begin
        if (!req[owner_q]) begin
          // Abandon: drop the interval without a done pulse.
          state_d   = ST_IDLE;
          cnt_clear = 1'b1;
          ptr_d     = ~owner_q;
        end else if (value == len_q) begin
          // Stopping on equality (not counting past) keeps the counter from wrapping.
          state_d = ST_DONE;
        end else begin
          state_d = ST_RUN;
          cnt_en  = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        ptr_d   = ~owner_q;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= 1'b0;
      owner_q <= 1'b0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      len_q   <= len_d;
    end
  end

  // Moore outputs, decoded purely from state flops.
  always_comb begin
    gnt     = '0;
    busy    = (state_q != ST_IDLE);
    done    = (state_q == ST_DONE);
    done_id = (state_q == ST_DONE) & owner_q;
    if (state_q == ST_LOAD || state_q == ST_RUN) gnt[owner_q] = 1'b1;
  end

endmodule
